// File: rtl/coh_pkg.sv
// coh_pkg
// Shared definitions for the coherence-side bus arbiter:
//   - default requester count and address/data widths
//   - read/write operation encodings
//   - the arbiter FSM state type
package coh_pkg;

  localparam int NUM_REQ_DEF = 3;
  localparam int ADDR_W_DEF  = 8;
  localparam int DATA_W_DEF  = 8;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// rr_pick
// Combinational round-robin selector.
// Searches the request vector starting one position after the last
// granted index, wrapping around, and returns a one-hot grant
// (all zero when nothing is requested).
// Ports:
//   req   in  N   request vector
//   last  in  PW  index of the most recently served requester
//   grant out N   one-hot winner
module rr_pick #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] last,
  output logic [N-1:0]  grant
);

  // Walk positions last+1, last+2, ... last+N (mod N); first hit wins.
  always_comb begin
    int          pos;
    logic        found;
    logic [PW-1:0] idx;
    grant = '0;
    found = 1'b0;
    pos   = 0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      pos = int'(last) + k;
      if (pos >= N) pos = pos - N;
      idx = PW'(pos);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter
// Round-robin arbiter that lets NUM_REQ processors share a single
// directory port with exactly one transaction outstanding at a time.
// A winner is accepted in IDLE, its fields are presented to the
// directory in ISSUE, and the completion (or a timeout abort) is
// returned to the source in WAIT_RESP.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   req_valid/op/addr/data  per-processor request (packed, slice i = proc i)
//   req_ready            one-hot acceptance pulse
//   dir_valid/op/addr/data/src, dir_ready  directory request handshake
//   resp_valid, resp_data   directory completion
//   done, rdata          one-hot completion pulse and its data
//   protocol_err         sticky error (stray response or timeout)
module bus_arbiter
  import coh_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 16,
  localparam int SRC_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_op,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      dir_valid,
  output logic                      dir_op,
  output logic [ADDR_W-1:0]         dir_addr,
  output logic [DATA_W-1:0]         dir_data,
  output logic [SRC_W-1:0]          dir_src,
  input  logic                      dir_ready,
  input  logic                      resp_valid,
  input  logic [DATA_W-1:0]         resp_data,
  output logic [NUM_REQ-1:0]        done,
  output logic [DATA_W-1:0]         rdata,
  output logic                      protocol_err
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  arb_state_t          state;
  logic [SRC_W-1:0]    last_grant;
  logic [7:0]          wait_cnt;
  logic [NUM_REQ-1:0]  grant;
  logic [SRC_W-1:0]    grant_idx;

  rr_pick #(
    .N  (NUM_REQ),
    .PW (SRC_W)
  ) u_pick (
    .req   (req_valid),
    .last  (last_grant),
    .grant (grant)
  );

  // Binary index of the one-hot winner, used to slice the packed fields.
  // Only valid request slices are ever selected, so garbage on idle
  // requesters never reaches the directory.
  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) grant_idx = SRC_W'(i);
    end
  end

  // Whole arbiter FSM with registered outputs. req_ready, done and rdata
  // are single-cycle pulses cleared by default every cycle. dir_valid is
  // raised one cycle after req_ready so the latched fields are stable
  // before the directory ever sees them. last_grant only moves when a
  // transaction finishes, so an aborted (reset) transaction does not
  // disturb priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      last_grant   <= SRC_W'(NUM_REQ - 1);
      wait_cnt     <= '0;
      protocol_err <= 1'b0;
      req_ready    <= '0;
      done         <= '0;
      rdata        <= '0;
      dir_valid    <= 1'b0;
      dir_op       <= 1'b0;
      dir_addr     <= '0;
      dir_data     <= '0;
      dir_src      <= '0;
    end else begin
      req_ready <= '0;
      done      <= '0;
      rdata     <= '0;
      case (state)
        ST_IDLE: begin
          if (resp_valid) protocol_err <= 1'b1;
          if (|req_valid) begin
            req_ready <= grant;
            dir_op    <= req_op[grant_idx];
            dir_addr  <= req_addr[grant_idx*ADDR_W +: ADDR_W];
            dir_data  <= req_data[grant_idx*DATA_W +: DATA_W];
            dir_src   <= grant_idx;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (resp_valid) protocol_err <= 1'b1;
          if (!dir_valid) begin
            dir_valid <= 1'b1;
          end else if (dir_ready) begin
            dir_valid <= 1'b0;
            wait_cnt  <= '0;
            state     <= ST_WAIT_RESP;
          end
        end
        ST_WAIT_RESP: begin
          if (resp_valid || (wait_cnt == TIMEOUT_LAST)) begin
            done <= NUM_REQ'(1) << dir_src;
            if (resp_valid && (dir_op == OP_READ)) rdata <= resp_data;
            if (!resp_valid) protocol_err <= 1'b1;
            last_grant <= dir_src;
            state      <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter
// Self-checking bench for bus_arbiter: directed scenarios followed by a
// randomized phase, all checked cycle by cycle against a transaction
// level reference model.
module tb_bus_arbiter;
  import coh_pkg::*;

  localparam int N  = 3;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int TO = 16;
  localparam int SW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_op = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_ready;
  logic            dir_valid;
  logic            dir_op;
  logic [AW-1:0]   dir_addr;
  logic [DW-1:0]   dir_data;
  logic [SW-1:0]   dir_src;
  logic            dir_ready = 1'b0;
  logic            resp_valid = 1'b0;
  logic [DW-1:0]   resp_data = '0;
  logic [N-1:0]    done;
  logic [DW-1:0]   rdata;
  logic            protocol_err;

  bus_arbiter #(
    .NUM_REQ (N),
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (TO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_op       (req_op),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .dir_valid    (dir_valid),
    .dir_op       (dir_op),
    .dir_addr     (dir_addr),
    .dir_data     (dir_data),
    .dir_src      (dir_src),
    .dir_ready    (dir_ready),
    .resp_valid   (resp_valid),
    .resp_data    (resp_data),
    .done         (done),
    .rdata        (rdata),
    .protocol_err (protocol_err)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  // Single comparison point: counts and reports.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one transaction in flight, described by its
  // lifecycle (granted -> shown to directory -> awaiting response).
  bit            m_busy, m_shown, m_wait, m_err;
  int            m_cnt, m_last, m_src;
  bit            m_op;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic [N-1:0]  e_ready, e_done;
  logic [DW-1:0] e_rdata;

  // Requester and directory behaviour knobs.
  bit            p_valid[N];
  bit            p_hold[N];
  bit            p_op[N];
  logic [AW-1:0] p_addr[N];
  logic [DW-1:0] p_data[N];
  bit            rand_req = 0;
  bit            dr_random = 0;
  bit            resp_random = 0;
  bit            stray_resp = 0;
  int            dr_low_left = 0;
  int            resp_after = 0;

  // Observation statistics.
  int cyc = 0, t_ready = -1, t_dv = -1, done_cnt = 0, dv_cnt = 0, ready_cnt = 0;
  logic [DW-1:0] last_rdata;
  int grant_log[$];

  function automatic int rrWinner(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  function automatic void modelReset();
    m_busy = 0; m_shown = 0; m_wait = 0; m_err = 0;
    m_cnt = 0; m_last = N - 1; m_src = 0;
  endfunction

  function automatic void modelStep(input logic [N-1:0] v, input logic [N-1:0] o,
                                    input logic [N*AW-1:0] a, input logic [N*DW-1:0] d,
                                    input logic dr, input logic rv, input logic [DW-1:0] rd);
    int w;
    e_ready = '0; e_done = '0; e_rdata = '0;
    if (!m_busy) begin
      if (rv) m_err = 1;
      w = rrWinner(v, m_last);
      if (w >= 0) begin
        m_busy = 1; m_shown = 0; m_wait = 0; m_src = w;
        m_op = o[w]; m_addr = a[w*AW +: AW]; m_data = d[w*DW +: DW];
        e_ready[w] = 1'b1;
      end
    end else if (!m_wait) begin
      if (rv) m_err = 1;
      if (!m_shown) m_shown = 1;
      else if (dr) begin m_shown = 0; m_wait = 1; m_cnt = 0; end
    end else begin
      if (rv || m_cnt == TO - 1) begin
        if (!rv) m_err = 1;
        e_done[m_src] = 1'b1;
        e_rdata = (rv && m_op == OP_READ) ? rd : '0;
        m_busy = 0; m_wait = 0; m_last = m_src;
      end else begin
        m_cnt++;
      end
    end
  endfunction

  function automatic void armReq(input int i);
    p_valid[i] = 1; p_op[i] = 1'($urandom);
    p_addr[i] = AW'($urandom); p_data[i] = DW'($urandom);
  endfunction

  function automatic void resetStats();
    cyc = 0; t_ready = -1; t_dv = -1; done_cnt = 0; dv_cnt = 0; ready_cnt = 0;
    last_rdata = '1;
    grant_log.delete();
  endfunction

  // One clock cycle: drive inputs, step model at the edge, compare at negedge.
  task automatic applyStimulus();
    logic [N-1:0] v, o;
    logic [N*AW-1:0] a;
    logic [N*DW-1:0] d;
    logic dr, rv;
    logic [DW-1:0] rd;
    for (int i = 0; i < N; i++) begin
      v[i] = p_valid[i];
      o[i] = p_valid[i] ? p_op[i] : 1'($urandom);
      a[i*AW +: AW] = p_valid[i] ? p_addr[i] : AW'($urandom);
      d[i*DW +: DW] = p_valid[i] ? p_data[i] : DW'($urandom);
    end
    if (m_shown && dr_low_left > 0) begin dr = 0; dr_low_left--; end
    else if (dr_random) dr = ($urandom_range(0, 3) != 0);
    else dr = 1;
    if (m_wait) rv = resp_random ? ($urandom_range(0, 5) == 0) : (resp_after >= 0 && m_cnt == resp_after);
    else rv = stray_resp;
    stray_resp = 0;
    rd = DW'($urandom);
    req_valid = v; req_op = o; req_addr = a; req_data = d;
    dir_ready = dr; resp_valid = rv; resp_data = rd;
    @(posedge clk);
    modelStep(v, o, a, d, dr, rv, rd);
    @(negedge clk);
    checkOutput("req_ready", req_ready, e_ready);
    checkOutput("done", done, e_done);
    checkOutput("dir_valid", dir_valid, m_shown);
    checkOutput("protocol_err", protocol_err, m_err);
    if (m_shown) begin
      checkOutput("dir_op", dir_op, m_op);
      checkOutput("dir_addr", dir_addr, m_addr);
      checkOutput("dir_data", dir_data, m_data);
      checkOutput("dir_src", dir_src, m_src);
    end
    if (e_done != 0) checkOutput("rdata", rdata, e_rdata);
    cyc++;
    if (req_ready != 0) begin
      ready_cnt++;
      if (t_ready < 0) t_ready = cyc;
      for (int i = 0; i < N; i++) if (req_ready[i]) grant_log.push_back(i);
    end
    if (dir_valid) begin dv_cnt++; if (t_dv < 0) t_dv = cyc; end
    if (done != 0) last_rdata = rdata;
    done_cnt += $countones(done);
    for (int i = 0; i < N; i++) begin
      if (e_ready[i]) begin
        if (p_hold[i]) armReq(i); else p_valid[i] = 0;
      end else if (rand_req && !p_valid[i] && $urandom_range(0, 3) == 0) begin
        armReq(i);
      end
    end
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear at once.
  task automatic doReset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput({tag, "_rst_ready"}, req_ready, 0);
    checkOutput({tag, "_rst_done"}, done, 0);
    checkOutput({tag, "_rst_dir_valid"}, dir_valid, 0);
    checkOutput({tag, "_rst_err"}, protocol_err, 0);
    checkOutput({tag, "_rst_fields"}, {dir_op, dir_src, dir_addr, dir_data}, 0);
    checkOutput({tag, "_rst_rdata"}, rdata, 0);
    modelReset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic runCycles(input int n);
    for (int k = 0; k < n; k++) applyStimulus();
  endtask

  initial begin
    modelReset();
    for (int i = 0; i < N; i++) begin p_valid[i] = 0; p_hold[i] = 0; end
    @(negedge clk);
    doReset("init");
    runCycles(2);

    // Lone write from P0, response two cycles into the wait.
    resetStats();
    p_valid[0] = 1; p_op[0] = OP_WRITE; p_addr[0] = 8'h05; p_data[0] = 8'h78;
    resp_after = 2;
    runCycles(12);
    checkOutput("t1_dv_after_ready", t_dv - t_ready, 1);
    checkOutput("t1_done_count", done_cnt, 1);
    checkOutput("t1_rdata", last_rdata, 0);
    checkOutput("t1_first_grant", grant_log.size() > 0 ? grant_log[0] : -1, 0);

    // Three continuous readers: strict rotation from P0.
    doReset("t2");
    resetStats();
    for (int i = 0; i < N; i++) begin armReq(i); p_op[i] = OP_READ; p_hold[i] = 1; end
    resp_after = 1;
    for (int k = 0; k < 80 && grant_log.size() < 4; k++) applyStimulus();
    checkOutput("t2_grant_count", grant_log.size() >= 4, 1);
    if (grant_log.size() >= 4) begin
      checkOutput("t2_grant0", grant_log[0], 0);
      checkOutput("t2_grant1", grant_log[1], 1);
      checkOutput("t2_grant2", grant_log[2], 2);
      checkOutput("t2_grant3", grant_log[3], 0);
    end
    for (int i = 0; i < N; i++) begin p_hold[i] = 0; p_valid[i] = 0; end
    runCycles(10);

    // Directory stalls five cycles: dir_valid held six cycles, one accept.
    resetStats();
    armReq(1);
    dr_low_left = 5; resp_after = 0;
    runCycles(14);
    checkOutput("t3_dv_cycles", dv_cnt, 6);
    checkOutput("t3_ready_count", ready_cnt, 1);
    checkOutput("t3_done_count", done_cnt, 1);

    // Silent directory: timeout abort, then a normal request still works.
    resetStats();
    armReq(2); p_op[2] = OP_READ;
    resp_after = -1;
    for (int k = 0; k < 40 && done_cnt == 0; k++) applyStimulus();
    checkOutput("t4_timeout_done", done_cnt, 1);
    checkOutput("t4_err", protocol_err, 1);
    checkOutput("t4_rdata", last_rdata, 0);
    resetStats();
    armReq(0); resp_after = 0;
    for (int k = 0; k < 20 && done_cnt == 0; k++) applyStimulus();
    checkOutput("t4_next_done", done_cnt, 1);

    // Stray response in IDLE: sticky error, no completion; reset clears.
    doReset("t5a");
    resetStats();
    runCycles(1);
    stray_resp = 1;
    runCycles(3);
    checkOutput("t5_err", protocol_err, 1);
    checkOutput("t5_no_done", done_cnt, 0);
    doReset("t5b");
    runCycles(1);

    // Reset while waiting for a response discards it; P0 first afterwards.
    resetStats();
    armReq(1); resp_after = -1;
    for (int k = 0; k < 20 && !m_wait; k++) applyStimulus();
    checkOutput("t6_reached_wait", m_wait, 1);
    runCycles(3);
    doReset("t6");
    runCycles(3);
    checkOutput("t6_no_done", done_cnt, 0);
    resetStats();
    armReq(2); armReq(1); armReq(0); resp_after = 0;
    for (int k = 0; k < 20 && grant_log.size() == 0; k++) applyStimulus();
    checkOutput("t6_first_grant", grant_log.size() > 0 ? grant_log[0] : -1, 0);
    runCycles(30);

    // Randomized traffic with periodic resets.
    rand_req = 1; dr_random = 1; resp_random = 1;
    for (int c = 0; c < 1500; c++) begin
      if (c % 400 == 399) doReset("rnd");
      stray_resp = ($urandom_range(0, 199) == 0);
      applyStimulus();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
